seq_data_compare: RTL and testbench
===================================

Name: seq_data_compare

Overview:
- Parametrised multi-cycle magnitude comparator; next generation of the 4/8-bit cascaded comparators.
- Captures two WIDTH-bit operands on a start pulse, then compares SLICE bits per clock from MSB to LSB.
- Reports A>B, A<B or A=B with a done pulse, in the same 3-bit result encoding as the existing comparators.
- Used by datapath blocks that need wide comparisons without a long combinational compare chain.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of SLICE.
- SLICE, 4, bits compared per clock cycle (1..WIDTH).
- EARLY_EXIT, 1, 1 = finish on the first unequal slice; 0 = always take NSLICE cycles (constant latency).

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRst  input  1  reset; asynchronous, active-high.
- iStart  input  1  start request; sampled only in IDLE.
- iData_a  input  WIDTH  operand A; captured on accepted start.
- iData_b  input  WIDTH  operand B; captured on accepted start.
- oBusy  output  1  high while in RUN.
- oDone  output  1  one-cycle pulse when oData is updated.
- oData  output  3  result: [2]=A>B, [1]=A<B, [0]=A=B; one-hot when valid.

Behaviour:
- NSLICE = WIDTH/SLICE. Internal slice index idx is clog2(NSLICE) bits wide, minimum 1 bit.
- Reset (iRst high, asynchronous): state=IDLE, oBusy=0, oDone=0, oData=3'b000, idx=0, operand registers=0.
- IDLE:
  - oDone is cleared every cycle unless a result is written in that cycle.
  - iStart=1 is accepted: latch iData_a and iData_b into internal registers, set idx=NSLICE-1, go to RUN, set oBusy=1.
  - oData holds the previous result until a new result is written.
- RUN, one slice per cycle:
  - Compare bits [idx*SLICE+SLICE-1 : idx*SLICE] of the latched A and B.
  - Slices unequal and EARLY_EXIT=1: write oData (100 or 010), pulse oDone, go to IDLE.
  - Slices unequal and EARLY_EXIT=0: record the first difference in a sticky flag and keep going.
  - idx==0 with no difference: write 001, pulse oDone, go to IDLE.
  - idx==0 with a sticky difference (EARLY_EXIT=0): write the recorded result, pulse oDone, go to IDLE.
  - Otherwise decrement idx.
- Latency:
  - oDone is asserted k cycles after the start-accept edge.
  - k = 1-based index, counted from the MSB, of the first unequal slice (EARLY_EXIT=1), or NSLICE otherwise.
- oDone and the new oData appear in the same cycle. oBusy drops in that cycle.
- Back-to-back: iStart=1 in the cycle oDone=1 (state IDLE) is accepted with no bubble.
- iStart while busy is ignored (no queuing). Changes on iData_a/iData_b during RUN have no effect.
- Reset during RUN aborts the compare with no oDone pulse, and all outputs take their reset values.
- SLICE==WIDTH: single-cycle compare, k=1 always.
- Unsigned compare by default.

Optional Feature:
- Macro: SEQ_DATA_COMPARE_SIGNED_EN.
- Defined:
  - Adds input port iSigned (1 bit), latched with the operands on start.
  - With iSigned=1, operands are two's complement: invert the operand MSB in the top-slice compare only.
  - Early-exit and latency rules are unchanged.
- Not defined: no iSigned port; always unsigned.

Test Plan:
- Equal operands, defaults: A=16'h1234, B=16'h1234, pulse iStart -> oBusy high 4 cycles; oDone on cycle 4; oData=3'b001.
- Early exit on first slice: A=16'h8000, B=16'h7FFF -> oDone 1 cycle after start; oData=3'b100. With EARLY_EXIT=0 -> oDone on cycle 4; oData=3'b100.
- LSB-only difference: A=16'h1230, B=16'h1231 -> oDone on cycle 4; oData=3'b010.
- Busy and back-to-back handling:
  - Change A/B and pulse iStart during RUN -> result still reflects the original operands.
  - New iStart in the oDone cycle -> accepted; second result follows with no gap.
- Reset mid-run: assert iRst in cycle 2 of RUN -> oBusy=0, oData=3'b000, no oDone pulse. Next start (A=5, B=3) -> oData=3'b100.
- With SEQ_DATA_COMPARE_SIGNED_EN: iSigned=1, A=16'h8000, B=16'h0001 -> oData=3'b010 after 1 cycle. Same operands with iSigned=0 -> oData=3'b100.

Source files
------------

// File: rtl/seq_data_compare.sv
// seq_data_compare: multi-cycle magnitude comparator, SLICE bits per clock, MSB first.
// Result encoding on oData: [2]=A>B, [1]=A<B, [0]=A=B.
// Optional macro SEQ_DATA_COMPARE_SIGNED_EN adds an iSigned input for two's-complement compares.
module seq_data_compare #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned SLICE      = 4,
   parameter int unsigned EARLY_EXIT = 1
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStart,
   input  logic [WIDTH-1:0] iData_a,
   input  logic [WIDTH-1:0] iData_b,
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
   input  logic             iSigned,
`endif
   output logic             oBusy,
   output logic             oDone,
   output logic [2:0]       oData
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [2:0]  RES_GT = 3'b100;
   localparam logic [2:0]  RES_LT = 3'b010;
   localparam logic [2:0]  RES_EQ = 3'b001;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_n;
   logic [IDXW-1:0]   idx_q, idx_n;
   logic [WIDTH-1:0]  a_q, a_n, b_q, b_n;
   logic              diff_q, diff_n;
   logic              gt_q, gt_n;
   logic              busy_n, done_n;
   logic [2:0]        data_n;
   logic [SLICE-1:0]  sa, sb;
   logic              neq, gt_now;
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
   logic              sgn_q, sgn_n;
`endif

   // Select the current slice of both operands; in signed mode the sign bit is flipped on the top slice
   always_comb begin
      sa = SLICE'(a_q >> (int'(idx_q) * SLICE));
      sb = SLICE'(b_q >> (int'(idx_q) * SLICE));
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
      if (sgn_q && (idx_q == IDXW'(NSLICE - 1))) begin
         sa[SLICE-1] = ~sa[SLICE-1];
         sb[SLICE-1] = ~sb[SLICE-1];
      end
`endif
      neq    = (sa != sb);
      gt_now = (sa > sb);
   end

   // Next-state and next-output logic
   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      a_n     = a_q;
      b_n     = b_q;
      diff_n  = diff_q;
      gt_n    = gt_q;
      busy_n  = oBusy;
      done_n  = 1'b0;
      data_n  = oData;
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
      sgn_n   = sgn_q;
`endif
      case (state_q)
         IDLE: begin
            if (iStart) begin
               a_n     = iData_a;
               b_n     = iData_b;
               idx_n   = IDXW'(NSLICE - 1);
               diff_n  = 1'b0;
               gt_n    = 1'b0;
               busy_n  = 1'b1;
               state_n = RUN;
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
               sgn_n   = iSigned;
`endif
            end
         end
         RUN: begin
            if (neq && (EARLY_EXIT != 0)) begin
               data_n  = gt_now ? RES_GT : RES_LT;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else if (idx_q == '0) begin
               // Last slice: the earliest recorded difference wins over this slice
               if (diff_q)
                  data_n = gt_q ? RES_GT : RES_LT;
               else if (neq)
                  data_n = gt_now ? RES_GT : RES_LT;
               else
                  data_n = RES_EQ;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               idx_n = idx_q - IDXW'(1);
               if (neq && !diff_q) begin
                  diff_n = 1'b1;
                  gt_n   = gt_now;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, operand and output registers
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= 1'b0;
         gt_q    <= 1'b0;
         oBusy   <= 1'b0;
         oDone   <= 1'b0;
         oData   <= 3'b000;
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
         sgn_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         a_q     <= a_n;
         b_q     <= b_n;
         diff_q  <= diff_n;
         gt_q    <= gt_n;
         oBusy   <= busy_n;
         oDone   <= done_n;
         oData   <= data_n;
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
         sgn_q   <= sgn_n;
`endif
      end
   end

endmodule

// File: tb/tb_seq_data_compare.sv
// Bench for seq_data_compare: three configurations (early exit, constant latency,
// single-slice) driven in parallel and checked every cycle against a behavioural model.
module tb_seq_data_compare;

   localparam int W = 16;
   localparam int NDUT = 3;
   localparam int SL [NDUT] = '{4, 4, 16};
   localparam int EE [NDUT] = '{1, 0, 1};

   logic          iClk = 1'b0;
   logic          iRst = 1'b1;
   logic          iStart = 1'b0;
   logic [W-1:0]  a = '0, b = '0;
   logic          sgn = 1'b0;
   logic [NDUT-1:0] busy, done;
   logic [2:0]    data [NDUT];

   int checks = 0;
   int errors = 0;

   always #5 iClk = ~iClk;

   seq_data_compare #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(1)) u0 (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iData_a(a), .iData_b(b),
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
      .iSigned(sgn),
`endif
      .oBusy(busy[0]), .oDone(done[0]), .oData(data[0]));

   seq_data_compare #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(0)) u1 (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iData_a(a), .iData_b(b),
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
      .iSigned(sgn),
`endif
      .oBusy(busy[1]), .oDone(done[1]), .oData(data[1]));

   seq_data_compare #(.WIDTH(16), .SLICE(16), .EARLY_EXIT(1)) u2 (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iData_a(a), .iData_b(b),
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
      .iSigned(sgn),
`endif
      .oBusy(busy[2]), .oDone(done[2]), .oData(data[2]));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: whole-word compare for the result; latency from the first differing slice
   function automatic void model_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                     input int sl, input int ee, output logic [2:0] r, output int k);
      int  n;
      int  mask;
      bit  found;
      logic gt;
      n = W / sl;
      mask = (sl >= 32) ? -1 : ((1 << sl) - 1);
      gt = s ? ($signed(x) > $signed(y)) : (x > y);
      r  = (x == y) ? 3'b001 : (gt ? 3'b100 : 3'b010);
      k  = n;
      found = 1'b0;
      if (ee != 0) begin
         for (int i = 0; i < n; i++) begin
            if (!found && (((32'(x) >> (W - (i + 1) * sl)) & mask) != ((32'(y) >> (W - (i + 1) * sl)) & mask))) begin
               k = i + 1;
               found = 1'b1;
            end
         end
      end
   endfunction

   logic       m_busy [NDUT];
   logic       m_done [NDUT];
   logic [2:0] m_data [NDUT];
   logic [2:0] m_exp  [NDUT];
   int         m_cnt  [NDUT];

   // Model update on each edge, then compare all outputs just after the edge
   always @(posedge iClk) begin
      for (int j = 0; j < NDUT; j++) begin
         if (iRst) begin
            m_busy[j] = 1'b0;
            m_done[j] = 1'b0;
            m_data[j] = 3'b000;
            m_cnt[j]  = 0;
         end else begin
            m_done[j] = 1'b0;
            if (m_busy[j]) begin
               m_cnt[j]--;
               if (m_cnt[j] == 0) begin
                  m_busy[j] = 1'b0;
                  m_done[j] = 1'b1;
                  m_data[j] = m_exp[j];
               end
            end else if (iStart) begin
               model_cmp(a, b, sgn, SL[j], EE[j], m_exp[j], m_cnt[j]);
               m_busy[j] = 1'b1;
            end
         end
      end
      #1;
      for (int j = 0; j < NDUT; j++) begin
         chk($sformatf("busy%0d", j), 32'(busy[j]), 32'(m_busy[j]));
         chk($sformatf("done%0d", j), 32'(done[j]), 32'(m_done[j]));
         chk($sformatf("data%0d", j), 32'(data[j]), 32'(m_data[j]));
      end
   end

   // One start pulse, then observe 12 cycles; latency counted from the accept edge
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        output int l0, output int l1, output logic [2:0] r0, output logic [2:0] r1);
      @(negedge iClk);
      a = x; b = y; iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      l0 = -1; l1 = -1; r0 = 3'b000; r1 = 3'b000;
      for (int c = 1; c <= 12; c++) begin
         @(posedge iClk);
         #1;
         if (done[0] && l0 < 0) begin l0 = c; r0 = data[0]; end
         if (done[1] && l1 < 0) begin l1 = c; r1 = data[1]; end
      end
   endtask

   initial begin
      int l0, l1;
      logic [2:0] r0, r1;
      logic [5:0] dpat;
      int p;

      #1;
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_done", 32'(done[0]), 32'd0);
      chk("rst_data", 32'(data[0]), 32'd0);
      repeat (2) @(negedge iClk);
      iRst = 1'b0;

      // Equal operands
      do_op(16'h1234, 16'h1234, l0, l1, r0, r1);
      chk("eq_lat", 32'(l0), 32'd4);
      chk("eq_res", 32'(r0), 32'b001);
      chk("eq_lat_const", 32'(l1), 32'd4);

      // Difference in the top slice
      do_op(16'h8000, 16'h7FFF, l0, l1, r0, r1);
      chk("top_lat", 32'(l0), 32'd1);
      chk("top_res", 32'(r0), 32'b100);
      chk("top_lat_const", 32'(l1), 32'd4);
      chk("top_res_const", 32'(r1), 32'b100);

      // Difference only in the bottom slice
      do_op(16'h1230, 16'h1231, l0, l1, r0, r1);
      chk("lsb_lat", 32'(l0), 32'd4);
      chk("lsb_res", 32'(r0), 32'b010);

      // Operand change and start during RUN are ignored
      @(negedge iClk);
      a = 16'h0001; b = 16'h0002; iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      @(negedge iClk);
      a = 16'h0009; b = 16'h0001; iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      r0 = 3'b000;
      l0 = -1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge iClk);
         #1;
         if (done[0] && l0 < 0) begin l0 = c; r0 = data[0]; end
      end
      chk("busy_ignore_res", 32'(r0), 32'b010);

      // Back-to-back: start held high is accepted again in the done cycle
      @(negedge iClk);
      a = 16'h8000; b = 16'h7FFF; iStart = 1'b1;
      dpat = '0;
      for (int c = 0; c < 6; c++) begin
         @(posedge iClk);
         #1;
         dpat[c] = done[0];
         if (c == 2) begin
            @(negedge iClk);
            iStart = 1'b0;
         end
      end
      chk("b2b_pattern", 32'(dpat), 32'b001010);
      repeat (8) @(negedge iClk);

      // Reset during RUN aborts with no done pulse
      @(negedge iClk);
      a = 16'h1234; b = 16'h1234; iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      @(negedge iClk);
      iRst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy[0]), 32'd0);
      chk("midrst_data", 32'(data[0]), 32'd0);
      chk("midrst_done", 32'(done[0]), 32'd0);
      @(negedge iClk);
      iRst = 1'b0;
      do_op(16'd5, 16'd3, l0, l1, r0, r1);
      chk("post_rst_lat", 32'(l0), 32'd4);
      chk("post_rst_res", 32'(r0), 32'b100);

`ifdef SEQ_DATA_COMPARE_SIGNED_EN
      sgn = 1'b1;
      do_op(16'h8000, 16'h0001, l0, l1, r0, r1);
      chk("signed_lat", 32'(l0), 32'd1);
      chk("signed_res", 32'(r0), 32'b010);
      sgn = 1'b0;
      do_op(16'h8000, 16'h0001, l0, l1, r0, r1);
      chk("unsigned_res", 32'(r0), 32'b100);
`endif

      // Randomized traffic: mixed equal, near-equal and random operands, occasional reset
      for (int n = 0; n < 3000; n++) begin
         @(negedge iClk);
         iStart = ($urandom % 4) == 0;
         iRst   = ($urandom % 300) == 0;
         a = 16'($urandom);
         p = $urandom % 4;
         case (p)
            0: b = 16'($urandom);
            1: b = a;
            2: b = a ^ (16'd1 << ($urandom % 16));
            default: b = {a[15:8], 8'($urandom)};
         endcase
`ifdef SEQ_DATA_COMPARE_SIGNED_EN
         sgn = 1'($urandom);
`endif
      end
      @(negedge iClk);
      iStart = 1'b0;
      iRst = 1'b0;
      repeat (10) @(negedge iClk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
